// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses instruction memory and loads the IF/ID register.
// Optional static backward-taken/forward-not-taken prediction via `STATIC_BTFN_EN.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF,
  parameter logic [3:0]  BR_OPCODE  = 4'hC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] im_instr,
  output logic [15:0] im_addr,
  output logic        im_rd_en,
  output logic [15:0] pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc1,
  output logic        if_id_valid,
  output logic        if_id_pred_tkn,
  output logic        fetch_halted
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALTED} state_t;

`ifdef STATIC_BTFN_EN
  localparam bit BTFN_ON = 1'b1;
`else
  localparam bit BTFN_ON = 1'b0;
`endif

  state_t      r_state, w_state_nx;
  logic [15:0] r_pc, w_pc_nx;
  logic [15:0] r_instr, w_instr_nx;
  logic [15:0] r_pc1, w_pc1_nx;
  logic        r_vld, w_vld_nx;
  logic        r_pred, w_pred_nx;

  logic [15:0] w_pc_inc, w_br_tgt, w_pc_seq;
  logic        w_is_hlt, w_pred;

  assign w_pc_inc = r_pc + 16'd1;
  assign w_br_tgt = w_pc_inc + {{7{im_instr[8]}}, im_instr[8:0]};
  assign w_is_hlt = (im_instr[15:12] == HLT_OPCODE);
  // Backward branches (negative imm9) are guessed taken; EX fixes any miss via redirect.
  assign w_pred   = BTFN_ON && (im_instr[15:12] == BR_OPCODE) && im_instr[8];
  assign w_pc_seq = w_pred ? w_br_tgt : w_pc_inc;

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_instr_nx = r_instr;
    w_pc1_nx   = r_pc1;
    w_vld_nx   = r_vld;
    w_pred_nx  = r_pred;
    if (redirect) begin
      w_state_nx = S_RUN;
      w_pc_nx    = redirect_pc;
      w_instr_nx = NOP_INSTR;
      w_pc1_nx   = 16'h0000;
      w_vld_nx   = 1'b0;
      w_pred_nx  = 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          w_state_nx = S_RUN;
          if (!stall) begin
            w_instr_nx = NOP_INSTR;
            w_pc1_nx   = 16'h0000;
            w_vld_nx   = 1'b0;
            w_pred_nx  = 1'b0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            w_instr_nx = im_instr;
            w_pc1_nx   = w_pc_inc;
            w_vld_nx   = 1'b1;
            w_pred_nx  = w_pred;
            // A fetched HLT freezes pc at its own address.
            if (w_is_hlt) w_state_nx = S_HALTED;
            else          w_pc_nx    = w_pc_seq;
          end
        end
        S_HALTED: begin
          if (!stall) begin
            w_instr_nx = NOP_INSTR;
            w_pc1_nx   = 16'h0000;
            w_vld_nx   = 1'b0;
            w_pred_nx  = 1'b0;
          end
        end
        default: w_state_nx = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_pc1   <= 16'h0000;
      r_vld   <= 1'b0;
      r_pred  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_instr <= w_instr_nx;
      r_pc1   <= w_pc1_nx;
      r_vld   <= w_vld_nx;
      r_pred  <= w_pred_nx;
    end
  end

  assign im_addr        = r_pc;
  assign im_rd_en       = (r_state == S_RUN) && !stall;
  assign pc             = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc1      = r_pc1;
  assign if_id_valid    = r_vld;
  assign if_id_pred_tkn = r_pred;
  assign fetch_halted   = (r_state == S_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table checked through a scoreboard queue,
// plus a hand-written mid-operation reset sequence.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] im_instr;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] pc, if_id_instr, if_id_pc1;
  logic        if_id_valid, if_id_pred_tkn, fetch_halted;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_instr(im_instr), .im_addr(im_addr),
    .im_rd_en(im_rd_en), .pc(pc), .if_id_instr(if_id_instr),
    .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid),
    .if_id_pred_tkn(if_id_pred_tkn), .fetch_halted(fetch_halted)
  );

  // Instruction memory image: 1234 at 0..3, HLT at 9, backward branch at 0x10.
  function automatic logic [15:0] imem(input logic [15:0] a);
    if (a <= 16'd3)         return 16'h1234;
    else if (a == 16'h0009) return 16'hF000;
    else if (a == 16'h0010) return 16'hC1FE;
    else                    return {4'h2, a[11:0]};
  endfunction

  assign im_instr = imem(im_addr);

  typedef struct {
    logic        st, rd;
    logic [15:0] rpc;
    logic        rden;
    logic [15:0] pc, instr, pc1;
    logic        vld, pred, halt;
  } vec_t;

  function automatic vec_t mk(input logic st, rd, input logic [15:0] rpc, input logic rden,
                              input logic [15:0] p, ins, p1, input logic v, pr, h);
    vec_t r;
    r.st = st; r.rd = rd; r.rpc = rpc; r.rden = rden;
    r.pc = p; r.instr = ins; r.pc1 = p1; r.vld = v; r.pred = pr; r.halt = h;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  localparam int NV = 25;
  vec_t tbl[NV];
  vec_t sb[$];

  initial begin
    vec_t e;
    logic [15:0] cur_pc;

    //             st rd rpc      rden pc       instr    pc1      v  pr h
    tbl[0]  = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0); // BOOT
    tbl[1]  = mk(0, 0, 16'h0000, 1, 16'h0001, 16'h1234, 16'h0001, 1, 0, 0);
    tbl[2]  = mk(0, 0, 16'h0000, 1, 16'h0002, 16'h1234, 16'h0002, 1, 0, 0);
    tbl[3]  = mk(0, 0, 16'h0000, 1, 16'h0003, 16'h1234, 16'h0003, 1, 0, 0);
    tbl[4]  = mk(0, 0, 16'h0000, 1, 16'h0004, 16'h1234, 16'h0004, 1, 0, 0);
    tbl[5]  = mk(0, 0, 16'h0000, 1, 16'h0005, 16'h2004, 16'h0005, 1, 0, 0);
    tbl[6]  = mk(1, 0, 16'h0000, 0, 16'h0005, 16'h2004, 16'h0005, 1, 0, 0); // stall
    tbl[7]  = mk(1, 0, 16'h0000, 0, 16'h0005, 16'h2004, 16'h0005, 1, 0, 0); // stall
    tbl[8]  = mk(0, 0, 16'h0000, 1, 16'h0006, 16'h2005, 16'h0006, 1, 0, 0);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 16'h0007, 16'h2006, 16'h0007, 1, 0, 0);
    tbl[10] = mk(1, 1, 16'h0040, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0); // redirect+stall
    tbl[11] = mk(0, 0, 16'h0000, 1, 16'h0041, 16'h2040, 16'h0041, 1, 0, 0);
    tbl[12] = mk(0, 1, 16'h0007, 1, 16'h0007, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[13] = mk(0, 0, 16'h0000, 1, 16'h0008, 16'h2007, 16'h0008, 1, 0, 0);
    tbl[14] = mk(0, 0, 16'h0000, 1, 16'h0009, 16'h2008, 16'h0009, 1, 0, 0);
    tbl[15] = mk(0, 0, 16'h0000, 1, 16'h0009, 16'hF000, 16'h000A, 1, 0, 1); // HLT
    tbl[16] = mk(0, 0, 16'h0000, 0, 16'h0009, 16'h0000, 16'h0000, 0, 0, 1);
    tbl[17] = mk(0, 0, 16'h0000, 0, 16'h0009, 16'h0000, 16'h0000, 0, 0, 1);
    tbl[18] = mk(0, 1, 16'h0002, 0, 16'h0002, 16'h0000, 16'h0000, 0, 0, 0); // resume
    tbl[19] = mk(0, 0, 16'h0000, 1, 16'h0003, 16'h1234, 16'h0003, 1, 0, 0);
    tbl[20] = mk(0, 1, 16'hFFFF, 1, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[21] = mk(0, 0, 16'h0000, 1, 16'h0000, 16'h2FFF, 16'h0000, 1, 0, 0); // wrap
    tbl[22] = mk(0, 1, 16'h0010, 1, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0);
`ifdef STATIC_BTFN_EN
    tbl[23] = mk(0, 0, 16'h0000, 1, 16'h000F, 16'hC1FE, 16'h0011, 1, 1, 0);
    tbl[24] = mk(0, 0, 16'h0000, 1, 16'h0010, 16'h200F, 16'h0010, 1, 0, 0);
`else
    tbl[23] = mk(0, 0, 16'h0000, 1, 16'h0011, 16'hC1FE, 16'h0011, 1, 0, 0);
    tbl[24] = mk(0, 0, 16'h0000, 1, 16'h0012, 16'h2011, 16'h0012, 1, 0, 0);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst pc", pc, 16'h0000);
    chk("rst instr", if_id_instr, 16'h0000);
    chk("rst pc1", if_id_pc1, 16'h0000);
    chk("rst valid", if_id_valid, 1'b0);
    chk("rst pred", if_id_pred_tkn, 1'b0);
    chk("rst halted", fetch_halted, 1'b0);
    chk("rst rden", im_rd_en, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    cur_pc = 16'h0000;
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      stall = tbl[i].st; redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d im_rd_en", i), im_rd_en, tbl[i].rden);
      chk($sformatf("v%0d im_addr", i), im_addr, cur_pc);
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      cur_pc = e.pc;
      chk($sformatf("v%0d pc", i), pc, e.pc);
      chk($sformatf("v%0d instr", i), if_id_instr, e.instr);
      chk($sformatf("v%0d pc1", i), if_id_pc1, e.pc1);
      chk($sformatf("v%0d valid", i), if_id_valid, e.vld);
      chk($sformatf("v%0d pred", i), if_id_pred_tkn, e.pred);
      chk($sformatf("v%0d halted", i), fetch_halted, e.halt);
    end

    // Async reset mid-operation drops a pending redirect immediately.
    @(negedge clk);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 16'h0080;
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst pc", pc, 16'h0000);
    chk("mid-rst valid", if_id_valid, 1'b0);
    chk("mid-rst instr", if_id_instr, 16'h0000);
    @(negedge clk);
    redirect = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post-rst boot rden", im_rd_en, 1'b0);
    @(posedge clk); #1;
    chk("post-rst boot pc", pc, 16'h0000);
    chk("post-rst boot valid", if_id_valid, 1'b0);
    @(posedge clk); #1;
    chk("post-rst pc", pc, 16'h0001);
    chk("post-rst instr", if_id_instr, 16'h1234);
    chk("post-rst pc1", if_id_pc1, 16'h0001);
    chk("post-rst valid", if_id_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
